// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: bus between the control FSM (master) and the core datapath/memories (slave).
//   pc, ifetch_req, dmem_req, dmem_we, op_code, imm_en, imm_out, rd/ra/rb_sel, reg_we, halted: master -> slave
//   ifetch_ack, instr_data, dmem_ack, rs_zero: slave -> master
interface cpu_ctrl_if #(parameter int ADDR_W = 8, parameter int DATA_W = 16);
  logic [ADDR_W-1:0] pc;
  logic              ifetch_req;
  logic              ifetch_ack;
  logic [DATA_W-1:0] instr_data;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic              rs_zero;
  logic [3:0]        op_code;
  logic              imm_en;
  logic [DATA_W-1:0] imm_out;
  logic [3:0]        rd_sel;
  logic [3:0]        ra_sel;
  logic [3:0]        rb_sel;
  logic              reg_we;
  logic              halted;
  modport master (
    output pc, ifetch_req, dmem_req, dmem_we, op_code, imm_en, imm_out,
           rd_sel, ra_sel, rb_sel, reg_we, halted,
    input  ifetch_ack, instr_data, dmem_ack, rs_zero
  );
  modport slave (
    input  pc, ifetch_req, dmem_req, dmem_we, op_code, imm_en, imm_out,
           rd_sel, ra_sel, rb_sel, reg_we, halted,
    output ifetch_ack, instr_data, dmem_ack, rs_zero
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle fetch/decode/execute control unit owning the PC and IR.
//   clk, rst (sync, active-high); bus: cpu_ctrl_if.master (fetch/data handshakes, decode fields, reg_we, halted).
//   CTRL_PERF_CNT_EN: adds retired_cnt/stall_cnt 16-bit wrapping counters.
module cpu_ctrl_fsm #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input logic clk,
  input logic rst,
  cpu_ctrl_if.master bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0] retired_cnt,
  output logic [15:0] stall_cnt
`endif
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, imm_pc;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [3:0] op;
  assign op = ir_q[15:12];
  assign pc_inc = pc_q + ADDR_W'(1);
  assign imm_pc = ADDR_W'(ir_q[7:0]);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    unique case (state_q)
      FETCH: begin
        ir_d = bus.ifetch_ack ? bus.instr_data : ir_q;
        state_d = bus.ifetch_ack ? DECODE : FETCH;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d = (op <= 4'd8) ? WB : (op == 4'd10 || op == 4'd11) ? MEM : (op == 4'd15) ? HALT : FETCH;
        pc_d = (op == 4'd12 || (op == 4'd13 && bus.rs_zero)) ? imm_pc : (state_d == FETCH) ? pc_inc : pc_q;
      end
      MEM: begin
        state_d = !bus.dmem_ack ? MEM : (op == 4'd10) ? WB : FETCH;
        pc_d = (bus.dmem_ack && op == 4'd11) ? pc_inc : pc_q;
      end
      WB: begin
        state_d = FETCH;
        pc_d = pc_inc;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end
  // fetch request is masked while rst is held so every output reads 0 during reset
  assign bus.ifetch_req = (state_q == FETCH) && !rst;
  assign bus.dmem_req = state_q == MEM;
  assign bus.dmem_we = (state_q == MEM) && (op == 4'd11);
  assign bus.pc = pc_q;
  assign bus.op_code = op;
  assign bus.imm_en = op == 4'd8;
  assign bus.imm_out = DATA_W'(ir_q[7:0]);
  assign bus.rd_sel = ir_q[11:8];
  assign bus.ra_sel = ir_q[7:4];
  assign bus.rb_sel = ir_q[3:0];
  assign bus.reg_we = state_q == WB;
  assign bus.halted = state_q == HALT;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] retired_q, retired_d, stall_q, stall_d;
  always_comb begin
    retired_d = retired_q + 16'((state_q != FETCH && state_d == FETCH) || (state_q != HALT && state_d == HALT));
    stall_d = stall_q + 16'((bus.ifetch_req && !bus.ifetch_ack) || (bus.dmem_req && !bus.dmem_ack));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q <= stall_d;
    end
  end
  assign retired_cnt = retired_q;
  assign stall_cnt = stall_q;
`endif
endmodule
